// File: rtl/hazard_ctl_pkg.sv
// Shared pipeline package: FSM encodings, timeout default and the
// control-bundle type used by the hazard controller.
package hazard_ctl_pkg;

   // FSM state encodings (kept as plain constants for legacy tools)
   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   // Default maximum MEM_WAIT length before mem_timeout sets
   localparam int TIMEOUT_CYCLES_DEF = 255;

   // Width and ceiling of the stall counter
   localparam int          STALL_W   = 16;
   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   // Pipeline control bundle produced every cycle
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_bubble;
   } ctl_t;

   // No-event response: every register loads, nothing is squashed
   function automatic ctl_t ctl_idle();
      ctl_t c;
      c.pc_en         = 1'b1;
      c.if_id_en      = 1'b1;
      c.id_ex_en      = 1'b1;
      c.ex_mem_en     = 1'b1;
      c.mem_wb_en     = 1'b1;
      c.if_id_flush   = 1'b0;
      c.id_ex_flush   = 1'b0;
      c.mem_wb_bubble = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/hazard_ctl_load_use.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write. Writes to $zero never count as a hazard.
module load_use_detect
   import hazard_ctl_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   output logic       hazard
);

   logic dest_nonzero;
   logic src_match;

   // Pure compare of the EX load destination against both ID sources
   always_comb begin
      dest_nonzero = (ex_rt != 5'd0);
      src_match    = (ex_rt == id_rs) || (ex_rt == id_rt);
      hazard       = ex_mem_read && dest_nonzero && src_match;
   end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: memory-wait freeze, load-use stall and branch
// flush, with a saturating stall counter and a sticky memory-timeout flag.
//
// Handshake: the MEM stage holds dmem_req high for an access; the access
// completes in any cycle where dmem_ready is also high. A cycle with
// dmem_req=1 and dmem_ready=0 is a wait cycle. Dropping dmem_req without
// ready ends the wait as if ready had been seen.
module hazard_ctl
   import hazard_ctl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        mem_wb_bubble,
   output logic [15:0] stall_cnt,
   output logic        mem_timeout,
   output logic        fsm_state
);

   // Wait counter just wide enough to hold TIMEOUT_CYCLES (assumed >= 1)
   localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int TO_INT    = TIMEOUT_CYCLES;
   localparam int TO_M1_INT = TIMEOUT_CYCLES - 1;
   localparam logic [WAIT_W-1:0] TO_VAL = TO_INT[WAIT_W-1:0];
   localparam logic [WAIT_W-1:0] TO_M1  = TO_M1_INT[WAIT_W-1:0];

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic              mem_wait;
   logic              load_use;
   ctl_t              ctl;
   logic [WAIT_W-1:0] wait_cnt;

   load_use_detect u_load_use (
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .hazard      (load_use)
   );

   // A wait cycle looks the same from RUN or MEM_WAIT: request without ready
   assign mem_wait = dmem_req && !dmem_ready;

   // Priority decode: memory wait > load-use stall > branch flush > idle.
   // A cycle that ends a wait is decoded like RUN, so a zero-wait access
   // or the completing cycle of a wait costs nothing extra.
   always_comb begin
      ctl       = ctl_idle();
      state_nxt = ST_RUN;
      if (mem_wait) begin
         ctl.pc_en         = 1'b0;
         ctl.if_id_en      = 1'b0;
         ctl.id_ex_en      = 1'b0;
         ctl.ex_mem_en     = 1'b0;
         ctl.mem_wb_en     = 1'b1;
         ctl.mem_wb_bubble = 1'b1;
         state_nxt         = ST_MEM_WAIT;
      end else if (load_use) begin
         // Hold PC and IF/ID, drop one bubble into ID/EX
         ctl.pc_en       = 1'b0;
         ctl.if_id_en    = 1'b0;
         ctl.id_ex_flush = 1'b1;
      end else if (branch_taken) begin
         ctl.if_id_flush = 1'b1;
      end
   end

   assign pc_en         = ctl.pc_en;
   assign if_id_en      = ctl.if_id_en;
   assign id_ex_en      = ctl.id_ex_en;
   assign ex_mem_en     = ctl.ex_mem_en;
   assign mem_wb_en     = ctl.mem_wb_en;
   assign if_id_flush   = ctl.if_id_flush;
   assign id_ex_flush   = ctl.id_ex_flush;
   assign mem_wb_bubble = ctl.mem_wb_bubble;
   assign fsm_state     = state;

   // FSM register; reset abandons any wait in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Saturating count of cycles in which the PC was held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!ctl.pc_en && (stall_cnt != STALL_MAX)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // Consecutive wait-cycle counter and sticky timeout; the wait itself
   // is not aborted when the timeout fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (mem_wait) begin
         if (wait_cnt != TO_VAL) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (wait_cnt >= TO_M1) begin
            mem_timeout <= 1'b1;
         end
      end else begin
         wait_cnt <= '0;
      end
   end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: id_rs, id_rt  in  5 each  source register addresses of the instruction in ID.
REQ-004 SHALL have ports: ex_mem_read  in  1  EX-stage instruction is a load; ex_rt  in  5  its destination.
REQ-005 SHALL have ports: branch_taken  in  1  branch/jump resolved taken in ID this cycle.
REQ-006 SHALL have ports: dmem_req  in  1  MEM stage issues a data-memory access; dmem_ready  in  1  access completes this cycle.
REQ-007 SHALL have ports: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
REQ-008 SHALL have ports: if_id_flush, id_ex_flush  out  1 each  force bubble (all control fields zero) into that register.
REQ-009 SHALL have ports: mem_wb_bubble  out  1  force w_reg_ctl_in and mem_to_reg_in of MEM/WB to zero.
REQ-010 SHALL have ports: stall_cnt  out  16  saturating count of stalled cycles; mem_timeout  out  1  sticky wait-timeout flag.
REQ-011 SHALL have parameter: TIMEOUT_CYCLES, default 255, maximum MEM_WAIT length before mem_timeout sets.

Function
REQ-012 SHALL implement states RUN and MEM_WAIT; outputs are combinational decode of state and current inputs.
REQ-013 Priority per cycle SHALL be: memory wait > load-use stall > branch flush.
REQ-014 Memory wait: in RUN or MEM_WAIT, dmem_req=1 with dmem_ready=0 SHALL give pc_en, if_id_en, id_ex_en, ex_mem_en = 0, mem_wb_en=1, mem_wb_bubble=1, and next state MEM_WAIT.
REQ-015 In MEM_WAIT, dmem_ready=1 SHALL give all enables 1, mem_wb_bubble=0, and next state RUN, so zero-wait access costs no cycles.
REQ-016 In MEM_WAIT, dmem_req falling to 0 without ready SHALL be treated as ready: return to RUN.
REQ-017 Load-use condition: ex_mem_read=1, ex_rt!=0, and ex_rt equals id_rs or id_rt.
REQ-018 On load-use in RUN: pc_en=0, if_id_en=0, id_ex_flush=1; other enables 1; state stays RUN; exactly one bubble is inserted.
REQ-019 branch_taken with no higher-priority event SHALL assert if_id_flush=1 for that cycle only; pc_en=1.
REQ-020 branch_taken during load-use or memory wait SHALL be ignored; ID holds and branch re-resolves later.
REQ-021 A write to register 0 (ex_rt=0) SHALL never cause a stall.
REQ-022 No event: all enables 1, all flush/bubble 0.
REQ-023 stall_cnt SHALL increment once per cycle with pc_en=0 and saturate at 0xFFFF.
REQ-024 A wait counter SHALL count consecutive MEM_WAIT cycles; on reaching TIMEOUT_CYCLES, mem_timeout SHALL set and remain 1 until reset; the wait continues.

Reset
REQ-025 rst_n=0 SHALL immediately force state RUN, stall_cnt=0, wait counter=0, mem_timeout=0, independent of clk.
REQ-026 During reset, enables SHALL be 1 and flush/bubble outputs 0, except that combinational hazard decode remains active.
REQ-027 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release, dmem_ready is not required to exit.

Structure
REQ-028 State encodings (RUN=0, MEM_WAIT=1) and TIMEOUT_CYCLES default SHALL live in the shared pipeline package.
REQ-029 Load-use compare SHALL be a sub-module load_use_detect (purely combinational); all other logic sits in hazard_ctl.

Verification
REQ-030 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt 0->1; next cycle with ex_mem_read=0 -> all enables 1.
REQ-031 $zero: ex_mem_read=1, ex_rt=0, id_rt=0 -> no stall, stall_cnt unchanged.
REQ-032 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles frozen with mem_wb_bubble=1, state back to RUN, stall_cnt=3.
REQ-033 Priority: dmem wait + load-use + branch_taken together -> only memory-wait response, if_id_flush=0, id_ex_flush=0.
REQ-034 Timeout: TIMEOUT_CYCLES=4, hold wait 6 cycles -> mem_timeout rises after the 4th wait cycle, stays 1 after ready, clears only on rst_n=0.
REQ-035 Async reset: drop rst_n mid-MEM_WAIT between clock edges -> state RUN, counters 0 immediately; saturation test: preload 0xFFFE, 3 stalls -> stall_cnt=0xFFFF.
